if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives the combinational instruction-memory read address, and registers the returned word into the IF/ID pipeline register. It also handles three control inputs from the ID stage: load-use stalls, taken branch/jump redirects, and flushes. It detects the HALT word, freezes fetch, and reports the halted state to the debug unit.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch.
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- i_stall  in  1: hold PC and IF/ID (load-use hazard from ID).
- i_flush  in  1: load a bubble into IF/ID on this edge.
- i_redirect  in  1: taken branch or jump resolved in ID.
- i_redirect_target  in  32: new PC; bits [1:0] ignored and forced to 00.
- o_imem_addr  out  32: current PC, driven combinationally from the PC register.
- i_imem_data  in  32: word read at o_imem_addr in the same cycle (combinational memory).
- o_if_id_instr  out  32: registered instruction; 0 (NOP) for a bubble.
- o_if_id_pc4  out  32: registered PC+4 of that instruction.
- o_if_id_valid  out  1: IF/ID holds a real fetched instruction.
- o_halted  out  1: fetch FSM is in HALTED.
- o_fetch_count  out  32: number of instructions accepted into IF/ID with valid=1.

## Operation
- FSM states: RUN and HALTED. Reset enters RUN. Only reset leaves HALTED.
- Per-edge priority in RUN:
  1. Redirect: PC ← {target[31:2],2'b00}; IF/ID ← bubble (no delay slot). Redirect overrides i_stall and the HALT check.
  2. Stall: PC and IF/ID hold. If i_flush is also set, IF/ID ← bubble and PC still holds.
  3. Flush: IF/ID ← bubble; PC ← PC+4.
  4. HALT word fetched: IF/ID ← {HALT_WORD, PC+4, valid=1}; PC holds; state → HALTED.
  5. Normal: IF/ID ← {i_imem_data, PC+4, valid=1}; PC ← PC+4.
- HALTED: PC holds. IF/ID ← bubble every edge, so the HALT word drains downstream. i_redirect, i_stall and i_flush are ignored.
- Bubble = instr 0, pc4 0, valid 0.
- o_fetch_count increments on every edge that loads valid=1 and wraps at 2^32. The HALT word counts.
- Arithmetic: PC+4 is a 32-bit modulo add, so 32'hFFFF_FFFC + 4 = 0. No alignment trap.

## Timing
- Reset values: PC=RESET_PC, o_imem_addr=RESET_PC, o_if_id_instr=0, o_if_id_pc4=0, o_if_id_valid=0, o_halted=0, o_fetch_count=0, state RUN.
- An asserted reset clears all state immediately, including mid-stall or mid-halt. The first fetch from RESET_PC is registered on the first edge after deassertion.
- Latency: the word at PC=X appears on o_if_id_* one edge after the PC becomes X.
- Redirect penalty: one bubble. The edge that samples i_redirect emits the bubble, and the target word appears on the following edge.
- o_halted rises on the edge that latches the HALT word into IF/ID.
- All outputs except o_imem_addr are registered.

## Structure
- The shared pipeline package holds:
  - the NOP constant 32'h0;
  - the HALT_WORD default;
  - the PC increment constant 4;
  - the fetch FSM state encoding (RUN=0, HALTED=1).
- One sub-module, if_id_register, implements the IF/ID latch with hold and bubble controls; the top keeps the PC, FSM and counter.
- Instruction memory is external, connected through o_imem_addr and i_imem_data.

## Test plan
- Reset, then feed memory words 0x20080001, 0x20090002, 0x200A0003 -> o_imem_addr steps 0,4,8; IF/ID shows each word with pc4 4,8,12 one edge later; o_fetch_count=3.
- i_stall high for 2 cycles at PC=8 -> PC stays 8 and IF/ID stays frozen; on release the word at 8 is latched with pc4=12, with no duplication.
- i_redirect with target 0x43 at PC=0x10 -> PC=0x40; one bubble (valid=0, instr 0); next IF/ID shows the word at 0x40 with pc4 0x44. Repeat with i_stall also asserted -> same result.
- HALT_WORD at address 0x0C -> IF/ID holds HALT_WORD, valid=1; o_halted=1; PC stays 0x0C; bubbles follow; i_redirect to 0 is ignored; o_fetch_count stops increasing.
- PC=0xFFFF_FFFC with a normal word -> pc4=0 and next PC=0.
- Assert reset while halted and mid-stall -> all outputs return immediately to their reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions used by the instruction-fetch stage and its IF/ID register.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INCR           = 32'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if_id_register.sv
// IF/ID pipeline latch: bubble wins over hold, hold wins over a normal load.
module if_id_register
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, RUN/HALTED fetch FSM, fetch counter and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic [31:0] o_fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  pc_plus4;
    logic         ifid_hold;
    logic         ifid_bubble;

    assign pc_plus4 = pc_q + PC_INCR;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (i_redirect) begin
                    // No delay slot: the word fetched alongside the redirect is squashed.
                    pc_d        = i_redirect_target & ~32'h3;
                    ifid_bubble = 1'b1;
                end else if (i_stall) begin
                    ifid_hold   = 1'b1;
                    ifid_bubble = i_flush;
                end else if (i_flush) begin
                    ifid_bubble = 1'b1;
                    pc_d        = pc_plus4;
                end else if (i_imem_data == HALT_WORD) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            ST_HALTED: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        count_d = (ifid_bubble || ifid_hold) ? count_q : count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_register u_if_id (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (ifid_hold),
        .bubble_i (ifid_bubble),
        .instr_i  (i_imem_data),
        .pc4_i    (pc_plus4),
        .instr_o  (o_if_id_instr),
        .pc4_o    (o_if_id_pc4),
        .valid_o  (o_if_id_valid)
    );

    assign o_imem_addr   = pc_q;
    assign o_halted      = (state_q == ST_HALTED);
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized checks of if_stage against a cycle-level behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stall, i_flush, i_redirect;
    logic [31:0] i_redirect_target, i_imem_data;
    logic [31:0] o_imem_addr, o_if_id_instr, o_if_id_pc4, o_fetch_count;
    logic        o_if_id_valid, o_halted;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_halted;

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .i_stall           (i_stall),
        .i_flush           (i_flush),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .o_imem_addr       (o_imem_addr),
        .i_imem_data       (i_imem_data),
        .o_if_id_instr     (o_if_id_instr),
        .o_if_id_pc4       (o_if_id_pc4),
        .o_if_id_valid     (o_if_id_valid),
        .o_halted          (o_halted),
        .o_fetch_count     (o_fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".addr"},   o_imem_addr,           m_pc);
        chk({where, ".instr"},  o_if_id_instr,         m_instr);
        chk({where, ".pc4"},    o_if_id_pc4,           m_pc4);
        chk({where, ".valid"},  {31'd0, o_if_id_valid}, {31'd0, m_valid});
        chk({where, ".halted"}, {31'd0, o_halted},      {31'd0, m_halted});
        chk({where, ".count"},  o_fetch_count,         m_count);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
    endtask

    task automatic bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic latch(input logic [31:0] w);
        m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_count = m_count + 32'd1;
    endtask

    // Called at a negedge; applies inputs, advances one clock, checks, returns at the next negedge.
    task automatic step(input logic st, input logic fl, input logic rd,
                        input logic [31:0] tgt, input logic [31:0] data);
        i_stall = st; i_flush = fl; i_redirect = rd;
        i_redirect_target = tgt; i_imem_data = data;
        #1 chk("pre.addr", o_imem_addr, m_pc);
        @(posedge clk);
        if (m_halted) begin
            bubble();
        end else if (rd) begin
            m_pc = {tgt[31:2], 2'b00};
            bubble();
        end else if (st) begin
            if (fl) bubble();
        end else if (fl) begin
            bubble();
            m_pc = m_pc + 32'd4;
        end else if (data == HALT) begin
            latch(data);
            m_halted = 1'b1;
        end else begin
            latch(data);
            m_pc = m_pc + 32'd4;
        end
        #1 check_all("step");
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("rst");
        @(posedge clk);
        #1 check_all("rst.hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] w);
        step(1'b0, 1'b0, 1'b0, 32'h0, w);
    endtask

    initial begin
        reset = 1'b1;
        i_stall = 1'b0; i_flush = 1'b0; i_redirect = 1'b0;
        i_redirect_target = 32'h0; i_imem_data = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("init");
        reset = 1'b0;

        // Straight-line fetch
        fetch(32'h2008_0001);
        fetch(32'h2009_0002);
        // Stall two cycles at PC=8, then release
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h200A_0003);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h200A_0003);
        fetch(32'h200A_0003);
        chk("plan.count3", o_fetch_count, 32'd3);
        fetch(32'h0000_0004);
        // Redirect at PC=0x10 to 0x43 -> 0x40
        step(1'b0, 1'b0, 1'b1, 32'h43, 32'h1111_1111);
        chk("plan.redir_pc", o_imem_addr, 32'h40);
        fetch(32'h2222_2222);
        chk("plan.redir_pc4", o_if_id_pc4, 32'h44);
        // Redirect with stall asserted
        step(1'b1, 1'b0, 1'b1, 32'h43, 32'h3333_3333);
        fetch(32'h4444_4444);
        // Stall together with flush, then plain flush
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_5555);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h6666_6666);
        // PC wrap at 0xFFFF_FFFC
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        fetch(32'h7777_7777);
        chk("plan.wrap_pc4", o_if_id_pc4, 32'h0);
        chk("plan.wrap_pc", o_imem_addr, 32'h0);

        // HALT at 0x0C, then ignored controls, then reset while halted
        do_reset();
        fetch(32'h2008_0001);
        fetch(32'h2009_0002);
        fetch(32'h200A_0003);
        fetch(HALT);
        chk("plan.halt_instr", o_if_id_instr, HALT);
        chk("plan.halt_pc", o_imem_addr, 32'h0C);
        step(1'b0, 1'b0, 1'b1, 32'h0, HALT);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("plan.halt_count", o_fetch_count, 32'd4);
        do_reset();
        fetch(32'h8888_8888);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h9999_9999);
        do_reset();
        fetch(32'hAAAA_AAAA);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            logic st, fl, rd;
            logic [31:0] d;
            st = ($urandom_range(99) < 20);
            fl = ($urandom_range(99) < 10);
            rd = ($urandom_range(99) < 10);
            d  = ($urandom_range(99) < 3) ? HALT : $urandom;
            if (m_halted && $urandom_range(9) == 0) do_reset();
            else step(st, fl, rd, $urandom, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
